muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M execute unit in the EX stage, downstream of instruction decode.
//  Fires when decode flags an M-type op (ALUOp=3'b011, funct7=7'b0000001).
//  MUL* ops take 2 cycles; DIV/REM ops use an iterative radix-2 restoring divider.
//  busy drives the hazard unit, which stalls IF/ID/EX until done.
// PARAMETERS
//  XLEN      32  operand/result width
//  DIV_STEPS 32  divider iterations; must equal XLEN
// PORTS
//  clk     in   1     clock, rising edge
//  rst     in   1     asynchronous, active-low reset (0 = reset)
//  start   in   1     M-op present in EX; level, held by the pipeline while stalled
//  funct3  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op_a    in   XLEN  rs1 value after forwarding; sampled only at accept
//  op_b    in   XLEN  rs2 value after forwarding; sampled only at accept
//  flush   in   1     branch/jump flush of EX; aborts the op in flight
//  busy    out  1     stall request to the hazard unit
//  done    out  1     one-cycle pulse; result valid
//  result  out  XLEN  registered result; holds its value until the next done
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, count=0, all internal registers 0.
//  States IDLE, MUL, DIV, DONE.
//  Accept: state==IDLE && start && !flush. At that edge latch funct3, op_a, op_b:
//   - MUL ops   -> state MUL.
//   - DIV/REM   -> latch magnitudes and signs; state DIV, count=0.
//  busy = (state==MUL) | (state==DIV) | (state==IDLE & start & !flush). busy is
//   combinational so the stall takes effect in the start cycle.
//  MUL: 64-bit product of sign/zero-extended operands; 1 cycle, then DONE.
//   MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
//   Latency: done is high 2 cycles after the start cycle.
//  DIV: one restoring iteration per cycle; count increments each cycle.
//   When count==DIV_STEPS-1: apply sign fixup, write result, go to DONE.
//   done is high 33 cycles after the start cycle.
//  Sign fixup (DIV/REM): quotient is negated when the operand signs differ;
//   remainder takes the sign of the dividend.
//  Special cases (apply regardless of timing):
//   - divisor 0: quotient=32'hFFFFFFFF, remainder=op_a (signed and unsigned).
//   - DIV overflow, 0x80000000 / -1: quotient=0x80000000, remainder=0.
//  DONE: done=1 and busy=0 for exactly 1 cycle; start is ignored (same instruction
//   is leaving EX); then state=IDLE. Back-to-back M-ops: the next one is accepted in
//   the cycle after DONE.
//  Flush: from MUL or DIV, go to IDLE at the next edge; no done, result unchanged.
//   Flush together with start in IDLE means no accept.
//  Reset asserted mid-op: immediately IDLE, with all outputs at reset values.
//  start low while in MUL/DIV (must not happen): ignored; the op completes.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN:
//   - Defined: divisor==0 and DIV overflow are detected at accept; go straight to
//     DONE with the special-case result (done 2 cycles after start).
//   - Undefined: these cases run all 32 iterations and the result is overridden at
//     finalize (done 33 cycles after start).
//   Results are identical in both builds; only latency differs.
// STRUCTURE
//  riscv_pkg: localparams for the M funct3 codes (F3_MUL..F3_REMU), ALUOP_MTYPE=3'b011,
//   FUNCT7_MEXT=7'b0000001, and the state encodings.
//  One sub-module, muldiv_div_iter: a single restoring step
//   (rem, quo, divisor -> rem', quo'), combinational, instantiated once.
// TESTING
//  1. MUL 7 x 0xFFFFFFFD (-3): done 2 cycles after start, result=0xFFFFFFEB; busy high 2 cycles.
//  2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000;
//     MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  3. DIVU 100/7 -> 14, done 33 cycles after start; REM 0xFFFFFFF9 (-7) % 2 -> 0xFFFFFFFF.
//  4. DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
//     check latency 2 with MULDIV_EARLY_OUT_EN defined and 33 without.
//  5. Flush at iteration 10 of a DIV: IDLE next cycle, no done, result keeps its prior
//     value; a new MUL issued the next cycle completes normally.
//  6. rst low at iteration 5 of a DIV: busy/done/result go to 0 asynchronously;
//     back-to-back DIVU then MUL: second op accepted the cycle after the first done.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared constants for the RV32M execute unit: M-extension funct3 codes,
//   the decode qualifiers that identify an M-type op, and the state
//   encoding of the multiply/divide sequencer.
//   Optional feature macro used by muldiv_unit: MULDIV_EARLY_OUT_EN.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] ALUOP_MTYPE = 3'b011;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    // DIV and REM are the signed divide ops (funct3[0] clear).
    function automatic logic is_signed_div(input logic [2:0] f3);
        return f3[2] & ~f3[0];
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// ---------------------------------------------------------------------------
// muldiv_div_iter
//   One radix-2 restoring division step, purely combinational.
//   Ports:
//     rem_in   partial remainder (always < divisor for a non-zero divisor)
//     quo_in   dividend bits not yet consumed, shifted left each step
//     divisor  divisor magnitude
//     rem_out  next partial remainder
//     quo_out  next quotient/dividend shift register
// ---------------------------------------------------------------------------
module muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    // Top bit of diff is the borrow: set means the trial subtraction fails
    // and the shifted remainder is kept (restored).
    assign rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle RV32M execute unit. Multiplies take two cycles to done;
//   divides/remainders run a 32-step restoring divider (33 cycles to done).
//   Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow
//   are detected at accept and finish on the two-cycle path instead.
//   Ports:
//     clk     rising-edge clock
//     rst     asynchronous active-low reset
//     start   M-op present in EX (level, held while stalled)
//     funct3  M-op select
//     op_a    rs1 value, sampled at accept
//     op_b    rs2 value, sampled at accept
//     flush   abort the op in flight
//     busy    stall request (combinational)
//     done    one-cycle result-valid pulse
//     result  registered result, held until the next done
// ---------------------------------------------------------------------------
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CNT_W   = $clog2(DIV_STEPS);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV_STEPS - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    state_t            state_reg, state_next;
    logic [2:0]        f3_reg;
    logic [XLEN-1:0]   a_reg, b_reg;
    logic [XLEN-1:0]   rem_reg, quo_reg, dvsr_reg;
    logic              neg_a_reg, neg_b_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [XLEN-1:0]   result_reg;

    // Divide-by-zero and INT_MIN / -1 bypass the divider's natural answer.
    function automatic logic is_special(input logic [2:0] f3,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        return (b == '0) || (is_signed_div(f3) && a == INT_MIN && b == '1);
    endfunction

    // funct3[1] selects remainder over quotient within the divide group.
    function automatic logic [XLEN-1:0] special_value(input logic [2:0] f3,
                                                      input logic [XLEN-1:0] a,
                                                      input logic [XLEN-1:0] b);
        if (b == '0)
            return f3[1] ? a : '1;
        else
            return f3[1] ? '0 : a;
    endfunction

    logic accept;
    assign accept = (state_reg == ST_IDLE) && start && !flush;
    assign busy   = (state_reg == ST_MUL) || (state_reg == ST_DIV) || accept;
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;

    // Operand magnitudes and signs for the divider, taken from the live inputs.
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    assign a_neg = is_signed_div(funct3) & op_a[XLEN-1];
    assign b_neg = is_signed_div(funct3) & op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // Multiply on 33-bit sign- or zero-extended operands.
    logic                    sx_a, sx_b;
    logic signed [2*XLEN+1:0] prod_full;
    logic [1:0]              unused_prod_hi;
    logic [XLEN-1:0]         mul_value, mul_final;
    assign sx_a = (f3_reg == F3_MULH) || (f3_reg == F3_MULHSU);
    assign sx_b = (f3_reg == F3_MULH);
    assign prod_full = $signed({sx_a & a_reg[XLEN-1], a_reg})
                     * $signed({sx_b & b_reg[XLEN-1], b_reg});
    assign unused_prod_hi = prod_full[2*XLEN+1:2*XLEN];
    assign mul_value = (f3_reg == F3_MUL) ? prod_full[XLEN-1:0]
                                          : prod_full[2*XLEN-1:XLEN];
    // A divide op can only reach the MUL state through the early-out path.
    assign mul_final = is_div_op(f3_reg) ? special_value(f3_reg, a_reg, b_reg)
                                         : mul_value;

    // Divider step and finalize.
    logic [XLEN-1:0] rem_step, quo_step, quo_fix, rem_fix, div_final;

    muldiv_div_iter #(.XLEN(XLEN)) u_div_iter (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (dvsr_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    assign quo_fix   = (neg_a_reg ^ neg_b_reg) ? -quo_step : quo_step;
    assign rem_fix   = neg_a_reg ? -rem_step : rem_step;
    assign div_final = is_special(f3_reg, a_reg, b_reg) ? special_value(f3_reg, a_reg, b_reg)
                     : (f3_reg[1] ? rem_fix : quo_fix);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_div_op(funct3))
                        state_next = ST_MUL;
                    else if (EARLY_OUT && is_special(funct3, op_a, op_b))
                        state_next = ST_MUL;
                    else
                        state_next = ST_DIV;
                end
            end
            ST_MUL:  state_next = flush ? ST_IDLE : ST_DONE;
            ST_DIV: begin
                if (flush)
                    state_next = ST_IDLE;
                else if (count_reg == LAST)
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            dvsr_reg   <= '0;
            neg_a_reg  <= 1'b0;
            neg_b_reg  <= 1'b0;
            count_reg  <= '0;
            result_reg <= '0;
        end else begin
            if (accept) begin
                f3_reg    <= funct3;
                a_reg     <= op_a;
                b_reg     <= op_b;
                neg_a_reg <= a_neg;
                neg_b_reg <= b_neg;
                quo_reg   <= a_mag;
                dvsr_reg  <= b_mag;
                rem_reg   <= '0;
                count_reg <= '0;
            end
            if (state_reg == ST_MUL && !flush)
                result_reg <= mul_final;
            if (state_reg == ST_DIV && !flush) begin
                rem_reg   <= rem_step;
                quo_reg   <= quo_step;
                count_reg <= count_reg + CNT_W'(1);
                if (count_reg == LAST)
                    result_reg <= div_final;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed, table-driven bench for muldiv_unit plus hand-written
//   sequences for flush, asynchronous reset and back-to-back issue.
//   Latency of the divide special cases follows MULDIV_EARLY_OUT_EN.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    import riscv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Entered #1 after a rising edge; that cycle is cycle 0 of the op.
    // Returns the cycle index at which done is seen and busy cycles before it.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit drop, input bit scramble,
                          output int lat, output logic [31:0] res, output int bcnt);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        lat = 999; bcnt = 0;
        #1;
        if (busy) bcnt++;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            // Operands must only matter at accept.
            if (scramble && c == 1) begin op_a = ~a; op_b = ~b; end
            if (done) begin lat = c; break; end
            if (busy) bcnt++;
        end
        res = result;
        if (drop) start = 1'b0;
    endtask

    initial begin
        int          lat, bcnt, seen;
        logic [31:0] res, prev;

        tbl[0]  = '{F3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 2};
        tbl[1]  = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2};
        tbl[2]  = '{F3_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 2};
        tbl[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 2};
        tbl[4]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2};
        tbl[5]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2};
        tbl[6]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14,       33};
        tbl[7]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        tbl[8]  = '{F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPEC_LAT};
        tbl[9]  = '{F3_REMU,   32'd5,        32'd0,        32'd5,        SPEC_LAT};
        tbl[10] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT};
        tbl[11] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPEC_LAT};
        tbl[12] = '{F3_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33};
        tbl[13] = '{F3_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33};
        tbl[14] = '{F3_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33};
        tbl[15] = '{F3_DIVU,   32'hFFFFFFFF, 32'd10,       32'h19999999, 33};
        tbl[16] = '{F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 2};

        // Reset state
        #23;
        chk("reset_busy",   {31'b0, busy}, 32'd0);
        chk("reset_done",   {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, 1'b1, 1'b1, lat, res, bcnt);
            $display("vec %0d f3=%0d a=0x%08h b=0x%08h result=0x%08h latency=%0d",
                     i, tbl[i].f3, tbl[i].a, tbl[i].b, res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].res);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, tbl[i].lat);
            chk($sformatf("vec%0d_busy_in_done", i), {31'b0, busy}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
            chk($sformatf("vec%0d_result_hold", i), result, tbl[i].res);
        end

        // Flush at iteration 10 of a DIVU
        prev = tbl[NV-1].res;
        funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        for (int c = 0; c < 11; c++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        $display("flush at iteration 10: busy=%0b done=%0b result=0x%08h", busy, done, result);
        chk("flush_busy",   {31'b0, busy}, 32'd0);
        chk("flush_done",   {31'b0, done}, 32'd0);
        chk("flush_result", result, prev);
        seen = 0;
        for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (done) seen++; end
        chk("flush_no_done", seen, 32'd0);
        run_op(F3_MUL, 32'd6, 32'd7, 1'b1, 1'b0, lat, res, bcnt);
        $display("post-flush MUL result=0x%08h latency=%0d", res, lat);
        chk("postflush_mul_result",  res, 32'd42);
        chk("postflush_mul_latency", lat, 32'd2);
        @(posedge clk); #1;

        // Asynchronous reset at iteration 5 of a DIV
        funct3 = F3_DIV; op_a = 32'hFFFFFF9C; op_b = 32'd7; start = 1'b1;
        for (int c = 0; c < 6; c++) begin @(posedge clk); #1; end
        #3;
        rst = 1'b0; start = 1'b0;
        #1;
        $display("reset mid-divide: busy=%0b done=%0b result=0x%08h", busy, done, result);
        chk("midrst_busy",   {31'b0, busy}, 32'd0);
        chk("midrst_done",   {31'b0, done}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("postrst_busy", {31'b0, busy}, 32'd0);

        // Back-to-back DIVU then MUL with start held throughout
        run_op(F3_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, lat, res, bcnt);
        $display("b2b DIVU result=0x%08h latency=%0d", res, lat);
        chk("b2b_divu_result",  res, 32'd14);
        chk("b2b_divu_latency", lat, 32'd33);
        run_op(F3_MUL, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0, lat, res, bcnt);
        $display("b2b MUL result=0x%08h cycles_from_prev_done=%0d", res, lat);
        chk("b2b_mul_result",  res, 32'hFFFE0001);
        chk("b2b_mul_latency", lat, 32'd3);
        chk("b2b_mul_busy",    bcnt, 32'd2);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
